// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU data-memory path.
// Holds the bridge FSM state type and the bus word / byte-enable widths.
// These widths must match the ones the datapath uses.
package cpu_bus_pkg;

    localparam int BUS_DW = 32;          // bus data / address word width
    localparam int BUS_SW = BUS_DW / 8;  // byte-enable width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
// Turns the core's single-cycle data-memory port into a request/response
// bus access with variable latency. While an access is in flight it asks
// the pipeline to stall. Read data comes back as a full word.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ram_ce_i ... wdata_i  core access (level, held while stalled)
//   ram_rdata_o           registered read data returned to MEM
//   stall_req_o           combinational stall request to the pipeline
//   bus_err_o             one-cycle pulse in DONE after a timeout abort
//   bus_req_o, bus_*_o    bus request and a registered copy of the access
//   bus_addr_ok_i         slave accepted the request this cycle
//   bus_data_ok_i         data valid / write complete this cycle
//   bus_rdata_i           read data, valid with bus_data_ok_i
module mem_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [BUS_SW-1:0] ram_sel_i,
    input  logic [BUS_DW-1:0] ram_addr_i,
    input  logic [BUS_DW-1:0] ram_wdata_i,
    output logic [BUS_DW-1:0] ram_rdata_o,
    output logic              stall_req_o,
    output logic              bus_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [BUS_SW-1:0] bus_sel_o,
    output logic [BUS_DW-1:0] bus_addr_o,
    output logic [BUS_DW-1:0] bus_wdata_o,
    input  logic              bus_addr_ok_i,
    input  logic              bus_data_ok_i,
    input  logic [BUS_DW-1:0] bus_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    bridge_state_t     state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic [BUS_DW-1:0] rdata_reg, rdata_next;
    logic              we_reg;
    logic [BUS_SW-1:0] sel_reg;
    logic [BUS_DW-1:0] addr_reg;
    logic [BUS_DW-1:0] wdata_reg;

    logic capture;      // accept a new access from the core
    logic data_hit;     // slave completed the access this cycle
    logic timeout_hit;  // last permitted WAIT cycle passed with no data

    // The counter reads k-1 during the k-th WAIT cycle, so the abort
    // fires in the TIMEOUT_CYCLES-th WAIT cycle. data_ok in that same
    // cycle takes priority over the abort.
    assign timeout_hit = (state_reg == WAIT) && !bus_data_ok_i &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        rdata_next = rdata_reg;
        capture    = 1'b0;
        data_hit   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ram_ce_i) begin
                    capture    = 1'b1;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus_addr_ok_i && bus_data_ok_i) begin
                    data_hit   = 1'b1;
                    state_next = DONE;
                end else if (bus_addr_ok_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (bus_data_ok_i) begin
                    data_hit   = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    rdata_next = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                // The core still holds ce here; going straight to IDLE
                // without capturing keeps the finished access from
                // being accepted a second time.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (data_hit && !we_reg) begin
            rdata_next = bus_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
            if (capture) begin
                we_reg    <= ram_we_i;
                sel_reg   <= ram_sel_i;
                addr_reg  <= ram_addr_i;
                wdata_reg <= ram_wdata_i;
            end
        end
    end

    assign stall_req_o = ((state_reg == IDLE) && ram_ce_i) ||
                         (state_reg == REQ) || (state_reg == WAIT);
    assign bus_req_o   = (state_reg == REQ);
    assign bus_err_o   = err_reg;
    assign ram_rdata_o = rdata_reg;
    assign bus_we_o    = we_reg;
    assign bus_sel_o   = sel_reg;
    assign bus_addr_o  = addr_reg;
    assign bus_wdata_o = wdata_reg;

endmodule
